chip8_draw_ctrl: RTL
====================

CHIP8_DRAW_CTRL -- requirements
Module: chip8_draw_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state and outputs.
REQ-003 SHALL have: draw  in  1  request to XOR one sprite row into the framebuffer.
REQ-004 SHALL have: x  in  6, y  in  5, draw_row_index  in  4, sprite_data  in  8  (bit7 = leftmost pixel).
REQ-005 SHALL have: clear  in  1  one-cycle request to zero the whole framebuffer.
REQ-006 SHALL have: fb_addr  out  8, fb_re  out  1, fb_we  out  1, fb_wdata  out  8, fb_rdata  in  8.
REQ-007 SHALL have: display_done  out  1  one-cycle completion pulse; collision  out  1; busy  out  1.
REQ-008 Framebuffer: 64x32 pixels, 256 bytes; byte address = row*8 + col[5:3]; byte bit7 = column col[5:3]*8.
REQ-009 fb_rdata SHALL be treated as valid in the cycle immediately after the cycle fb_re=1.

Function
REQ-010 States: IDLE, RD0, CAP0, WR0, RD1, CAP1, WR1, CLR, DONE.
REQ-011 IDLE: clear=1 -> CLR; else draw=1 and armed -> RD0; busy=0 only in IDLE.
REQ-012 clear and draw high in the same IDLE cycle: clear wins, draw ignored.
REQ-013 row = y + draw_row_index (5-bit sum); s = x[2:0]; left byte = sprite_data >> s; right byte = low 8 bits of (sprite_data << (8-s)).
REQ-014 Draw timing, draw sampled in cycle T: fb_re=1, fb_addr=left address in T+1; fb_rdata captured T+2; fb_we=1, fb_wdata = rdata XOR left byte in T+3.
REQ-015 s != 0: second byte at column byte (x[5:3]+1) same row; fb_re T+4, capture T+5, fb_we T+6, display_done T+7; s = 0: display_done T+4.
REQ-016 collision SHALL be 1 during display_done iff any bit set in both fb_rdata and the XOR mask of any byte written; else 0.
REQ-017 display_done and collision SHALL be single-cycle pulses, both 0 at all other times.
REQ-018 Re-arm: after display_done a new draw SHALL be accepted only once draw has been sampled 0 at least once.
REQ-019 fb_re and fb_we SHALL never be 1 in the same cycle; each is a single-cycle pulse.
REQ-020 x, y, draw_row_index, sprite_data SHALL be latched in cycle T; later input changes have no effect on that operation.
REQ-021 CLR: writes 8'h00 to addresses 0..255, one per cycle, ascending, 256 cycles; then display_done with collision=0.
REQ-022 draw or clear asserted while busy=1 SHALL be ignored (not queued).

Reset
REQ-023 On reset: state IDLE, armed=1, fb_addr=0, fb_re=0, fb_we=0, fb_wdata=0, display_done=0, collision=0, busy=0.
REQ-024 Reset mid-operation SHALL abort immediately; a partly done draw or clear is not completed or resumed.

Configuration
REQ-025 Macro CHIP8_DRAW_WRAP_EN selects edge behaviour.
REQ-026 Defined: column byte index and row wrap modulo 8 and 32 (byte 7 straddles into byte 0 of same row; row 35 -> row 3).
REQ-027 Undefined: straddle past byte 7 skipped (done at T+4); row > 31 clipped: no fb access, display_done at T+1, collision=0.

Verification
REQ-028 Reset, clear pulse -> 256 writes of 0 to addresses 0..255, display_done once, collision 0, busy high throughout.
REQ-029 x=0,y=0,idx=0,sprite=8'hF0 on zeroed fb -> write addr 0 data 8'hF0 at T+3, done T+4, collision 0; repeat -> data 8'h00, collision 1.
REQ-030 x=5,y=2,idx=1,sprite=8'hFF on zeroed fb -> addr 24 data 8'h07, addr 25 data 8'hF8, done T+7, collision 0.
REQ-031 x=60,y=31,idx=2,sprite=8'hFF: wrap build -> addr 15 data 8'h0F, addr 8 data 8'hF0; non-wrap build -> no access, done T+1.
REQ-032 draw held high across display_done -> no second operation until draw low one cycle; clear+draw same cycle -> clear only; reset at T+2 -> fb_we never asserted.

Source files
------------

// File: rtl/chip8_draw_ctrl.sv
// CHIP-8 sprite-row draw / framebuffer clear controller for a 64x32, 256-byte framebuffer.
// CHIP8_DRAW_WRAP_EN: when defined, columns and rows wrap at the screen edge; otherwise they clip.
module chip8_draw_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw,
  input  logic [5:0] x,
  input  logic [4:0] y,
  input  logic [3:0] draw_row_index,
  input  logic [7:0] sprite_data,
  input  logic       clear,
  output logic [7:0] fb_addr,
  output logic       fb_re,
  output logic       fb_we,
  output logic [7:0] fb_wdata,
  input  logic [7:0] fb_rdata,
  output logic       display_done,
  output logic       collision,
  output logic       busy
);

  localparam int unsigned ROW_W = 5;
  localparam int unsigned COL_W = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE, RD0, CAP0, WR0, RD1, CAP1, WR1, CLR, DONE
  } state_t;

  state_t state, state_d;

  logic              armed, armed_d;
  logic [BYTE_W-1:0] left_q, left_d;
  logic [BYTE_W-1:0] right_q, right_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col1_q, col1_d;
  logic              second_q, second_d;
  logic              coll_q, coll_d;

  logic [BYTE_W-1:0] fb_addr_d, fb_wdata_d;
  logic              fb_re_d, fb_we_d, done_d, collision_d, busy_d;

  // Operand decode from the live inputs, used only in the accepting IDLE cycle
  logic [ROW_W:0]    row_sum;
  logic [ROW_W-1:0]  row_in;
  logic [COL_W-1:0]  shift_in, col_in, col1_in;
  logic [BYTE_W-1:0] left_in, right_in;
  logic              row_ok, second_in;

  always_comb begin
    row_sum  = {1'b0, y} + {2'b00, draw_row_index};
    row_in   = row_sum[ROW_W-1:0];
    shift_in = x[2:0];
    col_in   = x[5:3];
    col1_in  = col_in + 3'd1;
    left_in  = sprite_data >> shift_in;
    right_in = sprite_data << (4'd8 - {1'b0, shift_in});
`ifdef CHIP8_DRAW_WRAP_EN
    row_ok    = 1'b1;
    second_in = (shift_in != 3'd0);
`else
    row_ok    = !row_sum[ROW_W];
    second_in = (shift_in != 3'd0) && (col_in != 3'd7);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      armed        <= 1'b1;
      left_q       <= '0;
      right_q      <= '0;
      row_q        <= '0;
      col1_q       <= '0;
      second_q     <= 1'b0;
      coll_q       <= 1'b0;
      fb_addr      <= '0;
      fb_re        <= 1'b0;
      fb_we        <= 1'b0;
      fb_wdata     <= '0;
      display_done <= 1'b0;
      collision    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      armed        <= armed_d;
      left_q       <= left_d;
      right_q      <= right_d;
      row_q        <= row_d;
      col1_q       <= col1_d;
      second_q     <= second_d;
      coll_q       <= coll_d;
      fb_addr      <= fb_addr_d;
      fb_re        <= fb_re_d;
      fb_we        <= fb_we_d;
      fb_wdata     <= fb_wdata_d;
      display_done <= done_d;
      collision    <= collision_d;
      busy         <= busy_d;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d     = state;
    armed_d     = armed;
    left_d      = left_q;
    right_d     = right_q;
    row_d       = row_q;
    col1_d      = col1_q;
    second_d    = second_q;
    coll_d      = coll_q;
    fb_addr_d   = fb_addr;
    fb_wdata_d  = fb_wdata;
    fb_re_d     = 1'b0;
    fb_we_d     = 1'b0;
    done_d      = 1'b0;
    collision_d = 1'b0;

    case (state)
      IDLE: begin
        if (clear) begin
          state_d    = CLR;
          fb_we_d    = 1'b1;
          fb_addr_d  = '0;
          fb_wdata_d = '0;
        end else if (draw && armed) begin
          left_d   = left_in;
          right_d  = right_in;
          row_d    = row_in;
          col1_d   = col1_in;
          second_d = second_in;
          coll_d   = 1'b0;
          if (!row_ok) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = RD0;
            fb_re_d   = 1'b1;
            fb_addr_d = {row_in, col_in};
          end
        end
      end
      RD0: state_d = CAP0;
      CAP0: begin
        state_d    = WR0;
        fb_we_d    = 1'b1;
        fb_wdata_d = fb_rdata ^ left_q;
        coll_d     = |(fb_rdata & left_q);
      end
      WR0: begin
        if (second_q) begin
          state_d   = RD1;
          fb_re_d   = 1'b1;
          fb_addr_d = {row_q, col1_q};
        end else begin
          state_d     = DONE;
          done_d      = 1'b1;
          collision_d = coll_q;
        end
      end
      RD1: state_d = CAP1;
      CAP1: begin
        state_d    = WR1;
        fb_we_d    = 1'b1;
        fb_wdata_d = fb_rdata ^ right_q;
        coll_d     = coll_q | (|(fb_rdata & right_q));
      end
      WR1: begin
        state_d     = DONE;
        done_d      = 1'b1;
        collision_d = coll_q;
      end
      CLR: begin
        if (fb_addr == 8'hFF) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          fb_we_d    = 1'b1;
          fb_addr_d  = fb_addr + 8'd1;
          fb_wdata_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A held draw must be seen low once after completion before the next one is taken
    if (done_d) armed_d = 1'b0;
    else if (!draw) armed_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

endmodule
